// File: rtl/mc_exec_pkg.sv
// ============================================================================
//  Module   : mc_exec_pkg
//  Purpose  : Op codes, condition codes, FSM encoding and flag bundle shared
//             by the multi-cycle execute datapath.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mc_exec_pkg;

   localparam logic [2:0] c_op_add = 3'b000;
   localparam logic [2:0] c_op_sub = 3'b001;
   localparam logic [2:0] c_op_rsb = 3'b010;
   localparam logic [2:0] c_op_and = 3'b011;
   localparam logic [2:0] c_op_not = 3'b100;
   localparam logic [2:0] c_op_mov = 3'b101;
   localparam logic [2:0] c_op_cmp = 3'b110;
   localparam logic [2:0] c_op_tst = 3'b111;

   localparam logic [1:0] c_cond_al = 2'b00;
   localparam logic [1:0] c_cond_eq = 2'b01;
   localparam logic [1:0] c_cond_gt = 2'b10;
   localparam logic [1:0] c_cond_nv = 2'b11;

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_read = 2'd1;
   localparam logic [1:0] c_st_exec = 2'd2;
   localparam logic [1:0] c_st_wb   = 2'd3;

   typedef struct packed {
      logic c;
      logic v;
      logic n;
      logic z;
   } flags_t;

endpackage

`default_nettype wire

// File: rtl/mc_exec_alu.sv
// ============================================================================
//  Module   : mc_exec_alu
//  Purpose  : Combinational ALU; one shared adder serves ADD/SUB/RSB/CMP.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_exec_alu
   import mc_exec_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output flags_t           flags
);

   logic [WIDTH-1:0] w_x;
   logic [WIDTH-1:0] w_yop;
   logic             w_cin;
   logic [WIDTH:0]   w_sum;

   // Subtraction is x + ~y + 1, so carry-out reads as "no borrow".
   always_comb begin
      w_x   = a;
      w_yop = b;
      w_cin = 1'b0;
      case (op)
         c_op_sub, c_op_cmp: begin w_yop = ~b; w_cin = 1'b1; end
         c_op_rsb:           begin w_x = b; w_yop = ~a; w_cin = 1'b1; end
         default: ;
      endcase
   end

   assign w_sum = {1'b0, w_x} + {1'b0, w_yop} + {{WIDTH{1'b0}}, w_cin};

   always_comb begin
      y       = w_sum[WIDTH-1:0];
      flags.c = w_sum[WIDTH];
      flags.v = (w_x[WIDTH-1] == w_yop[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);
      case (op)
         c_op_and, c_op_tst: y = a & b;
         c_op_not:           y = ~b;
         c_op_mov:           y = b;
         default: ;
      endcase
      if (op == c_op_and || op == c_op_tst || op == c_op_not || op == c_op_mov) begin
         flags.c = 1'b0;
         flags.v = 1'b0;
      end
      flags.n = y[WIDTH-1];
      flags.z = (y == '0);
   end

endmodule

`default_nettype wire

// File: rtl/mc_exec_dp.sv
// ============================================================================
//  Module   : mc_exec_dp
//  Purpose  : Four-state (IDLE/READ/EXEC/WB) conditional execute datapath with
//             register file and NZCV flags. Option: MC_EXEC_R0_ZERO_EN makes
//             register 0 read as zero and discard writes.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_exec_dp
   import mc_exec_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int NREG  = 16,
   localparam int AW    = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [1:0]       cond,
   input  logic             setf,
   input  logic             use_imm,
   input  logic [AW-1:0]    ra,
   input  logic [AW-1:0]    rb,
   input  logic [AW-1:0]    rd,
   input  logic [WIDTH-1:0] imm,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             c,
   output logic             v,
   output logic             n,
   output logic             z,
   input  logic [AW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [WIDTH-1:0] r_regs [NREG];
   logic [2:0]       r_op;
   logic [1:0]       r_cond;
   logic             r_setf;
   logic [AW-1:0]    r_rd;
   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;
   logic [WIDTH-1:0] r_result;
   flags_t           r_flags;
   flags_t           r_res_flags;
   logic             r_cond_ok;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] w_alu_y;
   flags_t           w_alu_flags;
   logic             w_cond_ok;
   logic             w_cmp_tst;
   logic             w_wr_en;
   logic             w_flag_en;

   always_ff @(posedge clk) begin
      if (rst) r_state <= c_st_idle;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle: if (start) w_state_nxt = c_st_read;
         c_st_read: w_state_nxt = c_st_exec;
         c_st_exec: w_state_nxt = c_st_wb;
         c_st_wb:   w_state_nxt = c_st_idle;
         default:   w_state_nxt = c_st_idle;
      endcase
   end

   always_comb begin
      busy = (r_state != c_st_idle);
      done = (r_state == c_st_wb);
   end

   always_comb begin
      w_a      = r_regs[ra];
      w_b      = r_regs[rb];
      dbg_data = r_regs[dbg_addr];
`ifdef MC_EXEC_R0_ZERO_EN
      if (ra == '0)       w_a      = '0;
      if (rb == '0)       w_b      = '0;
      if (dbg_addr == '0) dbg_data = '0;
`endif
   end

   mc_exec_alu #(.WIDTH(WIDTH)) u_alu (
      .op    (r_op),
      .a     (r_opa),
      .b     (r_opb),
      .y     (w_alu_y),
      .flags (w_alu_flags)
   );

   always_comb begin
      w_cond_ok = 1'b0;
      case (r_cond)
         c_cond_al: w_cond_ok = 1'b1;
         c_cond_eq: w_cond_ok = r_flags.z;
         c_cond_gt: w_cond_ok = !r_flags.z && (r_flags.n == r_flags.v);
         c_cond_nv: w_cond_ok = 1'b0;
         default:   w_cond_ok = 1'b0;
      endcase
   end

   assign w_cmp_tst = (r_op == c_op_cmp) || (r_op == c_op_tst);
   assign w_flag_en = (r_state == c_st_wb) && r_cond_ok && (r_setf || w_cmp_tst);
`ifdef MC_EXEC_R0_ZERO_EN
   assign w_wr_en = (r_state == c_st_wb) && r_cond_ok && !w_cmp_tst && (r_rd != '0);
`else
   assign w_wr_en = (r_state == c_st_wb) && r_cond_ok && !w_cmp_tst;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_op        <= '0;
         r_cond      <= '0;
         r_setf      <= 1'b0;
         r_rd        <= '0;
         r_opa       <= '0;
         r_opb       <= '0;
         r_result    <= '0;
         r_res_flags <= '0;
         r_cond_ok   <= 1'b0;
         r_flags     <= '0;
      end else begin
         if (r_state == c_st_read) begin
            r_op   <= op;
            r_cond <= cond;
            r_setf <= setf;
            r_rd   <= rd;
            r_opa  <= w_a;
            r_opb  <= use_imm ? imm : w_b;
         end
         if (r_state == c_st_exec) begin
            r_result    <= w_alu_y;
            r_res_flags <= w_alu_flags;
            r_cond_ok   <= w_cond_ok;
         end
         if (w_flag_en) r_flags <= r_res_flags;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else if (w_wr_en) begin
         r_regs[r_rd] <= r_result;
      end
   end

   assign result = r_result;
   assign c      = r_flags.c;
   assign v      = r_flags.v;
   assign n      = r_flags.n;
   assign z      = r_flags.z;

endmodule

`default_nettype wire

// File: tb/tb_mc_exec_dp.sv
// ============================================================================
//  Module   : tb_mc_exec_dp
//  Purpose  : Directed and random checks of mc_exec_dp against an arithmetic
//             reference model; honours MC_EXEC_R0_ZERO_EN for register 0.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mc_exec_dp;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = '0;
   logic [1:0]  cond = '0;
   logic        setf = 1'b0;
   logic        use_imm = 1'b0;
   logic [3:0]  ra = '0, rb = '0, rd = '0, dbg_addr = '0;
   logic [31:0] imm = '0;
   logic        busy, done, c, v, n, z;
   logic [31:0] result, dbg_data;

   int errors = 0;
   int checks = 0;

   logic [31:0] m_regs [16];
   logic        m_c, m_v, m_n, m_z;
   logic [31:0] m_result;

   mc_exec_dp #(.WIDTH(32), .NREG(16)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .cond(cond), .setf(setf),
      .use_imm(use_imm), .ra(ra), .rb(rb), .rd(rd), .imm(imm), .busy(busy),
      .done(done), .result(result), .c(c), .v(v), .n(n), .z(z),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mreg(input logic [3:0] i);
`ifdef MC_EXEC_R0_ZERO_EN
      if (i == 4'd0) return 32'd0;
`endif
      return m_regs[i];
   endfunction

   function automatic logic ovf(input longint s);
      return (s > 64'sd2147483647) || (s < -64'sd2147483648);
   endfunction

   // Reference behaviour of one operation, in plain integer arithmetic.
   task automatic model_exec(input logic [2:0] o, input logic [1:0] cd, input logic sf,
                             input logic ui, input logic [3:0] a_i, input logic [3:0] b_i,
                             input logic [3:0] d_i, input logic [31:0] im);
      logic [31:0] a, b;
      longint      sa, sb;
      logic        go, fc, fv;
      a  = mreg(a_i);
      b  = ui ? im : mreg(b_i);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      fc = 1'b0;
      fv = 1'b0;
      case (o)
         3'd0:       begin m_result = a + b; fc = (longint'(a) + longint'(b)) > 64'd4294967295; fv = ovf(sa + sb); end
         3'd1, 3'd6: begin m_result = a - b; fc = (a >= b); fv = ovf(sa - sb); end
         3'd2:       begin m_result = b - a; fc = (b >= a); fv = ovf(sb - sa); end
         3'd3, 3'd7: m_result = a & b;
         3'd4:       m_result = ~b;
         default:    m_result = b;
      endcase
      go = (cd == 2'd0) || (cd == 2'd1 && m_z) || (cd == 2'd2 && !m_z && m_n == m_v);
      if (go && o != 3'd6 && o != 3'd7) m_regs[d_i] = m_result;
      if (go && (sf || o == 3'd6 || o == 3'd7)) begin
         m_c = fc;
         m_v = fv;
         m_n = m_result[31];
         m_z = (m_result == 32'd0);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, "_flags"}, {28'd0, c, v, n, z}, {28'd0, m_c, m_v, m_n, m_z});
      for (int i = 0; i < 16; i++) begin
         dbg_addr = i[3:0];
         #1;
         check($sformatf("%s_reg%0d", tag, i), dbg_data, mreg(i[3:0]));
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [1:0] cd,
                         input logic sf, input logic ui, input logic [3:0] a_i,
                         input logic [3:0] b_i, input logic [3:0] d_i, input logic [31:0] im);
      int cyc;
      op = o; cond = cd; setf = sf; use_imm = ui; ra = a_i; rb = b_i; rd = d_i; imm = im;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 8) begin
         @(posedge clk); #1;
         cyc++;
      end
      model_exec(o, cd, sf, ui, a_i, b_i, d_i, im);
      check({tag, "_latency"}, cyc, 3);
      check({tag, "_result"}, result, m_result);
      @(posedge clk); #1;
      check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
      check_state(tag);
   endtask

   initial begin
      int nd;
      logic [31:0] corner [5];
      logic [31:0] rimm;
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      {m_c, m_v, m_n, m_z} = '0;
      m_result = '0;
      corner[0] = 32'h0; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h8000_0000;
      corner[3] = 32'h7FFF_FFFF; corner[4] = 32'h1;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_result", result, 32'd0);
      check_state("rst");

      run_op("mov5", 3'd5, 2'd0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd3, 32'd5);
      check("mov5_r3", m_regs[3], 32'd5);

      run_op("mov7f", 3'd5, 2'd0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd1, 32'h7FFF_FFFF);
      run_op("addovf", 3'd0, 2'd0, 1'b1, 1'b1, 4'd1, 4'd0, 4'd2, 32'd1);
      check("addovf_nvcz", {28'd0, n, v, c, z}, 32'b1100);
      check("addovf_r2", m_regs[2], 32'h8000_0000);

      run_op("mov4", 3'd5, 2'd0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd1, 32'd4);
      run_op("cmp4", 3'd6, 2'd0, 1'b0, 1'b1, 4'd1, 4'd0, 4'd1, 32'd4);
      check("cmp4_zc", {30'd0, z, c}, 32'b11);
      run_op("addeq", 3'd0, 2'd1, 1'b0, 1'b1, 4'd1, 4'd0, 4'd5, 32'd1);
      check("addeq_r5", m_regs[5], 32'd5);
      run_op("addgt", 3'd0, 2'd2, 1'b0, 1'b1, 4'd1, 4'd0, 4'd6, 32'd1);
      check("addgt_r6", m_regs[6], 32'd0);
      run_op("addnv", 3'd0, 2'd3, 1'b1, 1'b1, 4'd1, 4'd0, 4'd7, 32'd1);

      // start held across the busy cycles must yield a single operation
      op = 3'd5; cond = 2'd0; setf = 1'b0; use_imm = 1'b1; rd = 4'd4; imm = 32'h33;
      nd = 0;
      for (int i = 0; i < 10; i++) begin
         start = (i < 3);
         @(posedge clk); #1;
         if (done) nd++;
      end
      model_exec(3'd5, 2'd0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd4, 32'h33);
      check("busy_start_dones", nd, 1);
      check_state("busy_start");

      for (int k = 0; k < 40; k++) begin
         rimm = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         run_op($sformatf("rnd%0d", k), 3'($urandom), 2'($urandom), 1'($urandom),
                1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), rimm);
      end

      // reset landing while the op sits in EXEC
      op = 3'd0; cond = 2'd0; setf = 1'b1; use_imm = 1'b1; ra = 4'd3; rd = 4'd7; imm = 32'hFFFF_FFFF;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      nd = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (done) nd++;
      end
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      {m_c, m_v, m_n, m_z} = '0;
      check("abort_dones", nd, 0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_result", result, 32'd0);
      check_state("abort");

      run_op("mov9r0", 3'd5, 2'd0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 32'd9);
      dbg_addr = 4'd0;
      #1;
`ifdef MC_EXEC_R0_ZERO_EN
      check("r0_value", dbg_data, 32'd0);
`else
      check("r0_value", dbg_data, 32'd9);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
